// File: rtl/imm_gen_pipe_pkg.sv
// cpuDefine: definitions shared by the immediate generator and its neighbours.
//   Instr    - raw 32-bit instruction word
//   Itype    - immediate format selector (codes outside I8..I26 are undefined)
//   xword_t  - widest supported datapath word; XLEN-wide data is its low slice
//   sext()   - sign-extend the low w bits of a word to the full width
package cpuDefine;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned XLEN_MAX = 64;

  typedef logic [INSTR_W-1:0]  Instr;
  typedef logic [XLEN_MAX-1:0] xword_t;

  typedef enum logic [3:0] {
    IT_NONE = 4'd0,
    I8      = 4'd1,
    I12     = 4'd2,
    I14     = 4'd3,
    I16     = 4'd4,
    I20     = 4'd5,
    I21     = 4'd6,
    I26     = 4'd7
  } Itype;

  // Field positions and significant widths of each format, independent of XLEN.
  localparam int unsigned FLD_LO = 10;
  localparam int unsigned I20_LO = 5;
  localparam int unsigned W_I12  = 12;
  localparam int unsigned W_I14  = 16;
  localparam int unsigned W_I16  = 18;
  localparam int unsigned W_I20  = 32;
  localparam int unsigned W_I21  = 21;
  localparam int unsigned W_I26  = 28;

  function automatic xword_t sext(input xword_t v, input int unsigned w);
    xword_t sh;
    sh = v << (XLEN_MAX - w);
    return xword_t'($signed(sh) >>> (XLEN_MAX - w));
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Request/result bus of imm_gen_pipe.
//   master: requester side (drives request fields and out_ready)
//   slave : imm_gen_pipe side (drives in_ready and result fields)
interface imm_gen_pipe_if
  import cpuDefine::*;
#(
  parameter int unsigned XLEN = 32
) ();

  logic            in_valid;
  logic            in_ready;
  Instr            instr;
  Itype            itype;
  logic            unsign;
  logic            pcrel;
  logic [XLEN-1:0] pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] target;
  logic            bad_fmt;

  modport master (
    output in_valid, instr, itype, unsign, pcrel, pc, out_ready,
    input  in_ready, out_valid, imm, target, bad_fmt
  );

  modport slave (
    input  in_valid, instr, itype, unsign, pcrel, pc, out_ready,
    output in_ready, out_valid, imm, target, bad_fmt
  );

endinterface

// File: rtl/imm_gen_pipe_ext.sv
// imm_ext: combinational immediate decode and extension to XLEN.
//   instr   - raw instruction word
//   itype   - format selector
//   unsign  - zero-extend I12 instead of sign-extending
//   imm     - extended immediate (0 for undefined formats)
//   bad_fmt - itype is not a defined format
module imm_ext
  import cpuDefine::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  Instr            instr,
  input  Itype            itype,
  input  logic            unsign,
  output logic [XLEN-1:0] imm,
  output logic            bad_fmt
);

  // Extension is done at the widest width and sliced; sign extension to 64
  // then truncation equals sign extension to 32.
  xword_t ext;

  always_comb begin
    ext     = '0;
    bad_fmt = 1'b0;
    case (itype)
      I8:  ext = (XLEN == 64) ? xword_t'(instr[15:FLD_LO]) : xword_t'(instr[14:FLD_LO]);
      I12: ext = unsign ? xword_t'(instr[21:FLD_LO])
                        : sext(xword_t'(instr[21:FLD_LO]), W_I12);
      I14: ext = sext(xword_t'({instr[23:FLD_LO], 2'b00}), W_I14);
      I16: ext = sext(xword_t'({instr[25:FLD_LO], 2'b00}), W_I16);
      I20: ext = sext(xword_t'({instr[24:I20_LO], 12'h000}), W_I20);
      I21: ext = sext(xword_t'({instr[4:0], instr[25:FLD_LO]}), W_I21);
      I26: ext = sext(xword_t'({instr[9:0], instr[25:FLD_LO], 2'b00}), W_I26);
      default: bad_fmt = 1'b1;
    endcase
  end

  assign imm = ext[XLEN-1:0];

  logic unused_bits;
  assign unused_bits = ^{ext, instr[31:26]};

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: one-cycle immediate generator with a 2-entry output buffer
// (output stage + skid entry).
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   flush - synchronous flush; empties both entries and drops the request
//   bus   - request/result bus (slave side): in_valid/in_ready, instr, itype,
//           unsign, pcrel, pc; out_valid/out_ready, imm, target, bad_fmt
module imm_gen_pipe
  import cpuDefine::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter bit          PC_REL_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  imm_gen_pipe_if.slave      bus
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic            bad_fmt;
  } res_t;

  logic [XLEN-1:0] ext_imm;
  logic            ext_bad;
  res_t            new_res;

  res_t out_q, out_d, skid_q, skid_d;
  logic out_valid_q, out_valid_d;
  logic skid_valid_q, skid_valid_d;

  logic in_fire;
  logic out_fire;

  imm_ext #(.XLEN(XLEN)) u_imm_ext (
    .instr   (bus.instr),
    .itype   (bus.itype),
    .unsign  (bus.unsign),
    .imm     (ext_imm),
    .bad_fmt (ext_bad)
  );

  always_comb begin
    new_res         = '0;
    new_res.imm     = ext_imm;
    new_res.bad_fmt = ext_bad;
    if (PC_REL_EN && bus.pcrel && !ext_bad) begin
      new_res.target = bus.pc + ext_imm;
    end
  end

  // in_ready is purely the skid-empty flop, so out_ready never reaches it.
  assign in_fire  = bus.in_valid && !skid_valid_q;
  assign out_fire = out_valid_q && bus.out_ready;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_fire) begin
      // Output stage frees up: oldest pending result (skid) goes first.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_d       = new_res;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d       = new_res;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign bus.in_ready  = !skid_valid_q;
  assign bus.out_valid = out_valid_q;
  assign bus.imm       = out_q.imm;
  assign bus.target    = out_q.target;
  assign bus.bad_fmt   = out_q.bad_fmt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three instances (XLEN=32, XLEN=64, XLEN=32 without
// pc-relative adder) share one stimulus stream; a FIFO-of-requests model with
// arithmetic immediate reference predicts every output.
module tb_imm_gen_pipe;
  import cpuDefine::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, unsign, pcrel, out_ready;
  logic [31:0] instr;
  logic [3:0]  itype_raw;
  logic [63:0] pc;

  imm_gen_pipe_if #(.XLEN(32)) b32 ();
  imm_gen_pipe_if #(.XLEN(64)) b64 ();
  imm_gen_pipe_if #(.XLEN(32)) bnp ();

  assign b32.in_valid = in_valid;  assign b64.in_valid = in_valid;  assign bnp.in_valid = in_valid;
  assign b32.instr = instr;        assign b64.instr = instr;        assign bnp.instr = instr;
  assign b32.itype = Itype'(itype_raw);
  assign b64.itype = Itype'(itype_raw);
  assign bnp.itype = Itype'(itype_raw);
  assign b32.unsign = unsign;      assign b64.unsign = unsign;      assign bnp.unsign = unsign;
  assign b32.pcrel = pcrel;        assign b64.pcrel = pcrel;        assign bnp.pcrel = pcrel;
  assign b32.pc = pc[31:0];        assign b64.pc = pc;              assign bnp.pc = pc[31:0];
  assign b32.out_ready = out_ready; assign b64.out_ready = out_ready; assign bnp.out_ready = out_ready;

  imm_gen_pipe #(.XLEN(32), .PC_REL_EN(1'b1)) u_dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32));
  imm_gen_pipe #(.XLEN(64), .PC_REL_EN(1'b1)) u_dut64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64));
  imm_gen_pipe #(.XLEN(32), .PC_REL_EN(1'b0)) u_dutnp (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bnp));

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  t;
    logic        u;
    logic        p;
    logic [63:0] pc;
  } req_t;

  req_t q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  function automatic bit ref_bad(input logic [3:0] t);
    return !(t >= 4'd1 && t <= 4'd7);
  endfunction

  // Immediate as a plain number: pick the field, treat it as a w-bit two's
  // complement value when signed, then reduce modulo 2^xlen.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [3:0] t,
                                          input logic u, input int unsigned xlen);
    logic [63:0] v;
    int unsigned w;
    bit s;
    v = '0; w = 1; s = 1'b1;
    case (Itype'(t))
      I8:  begin s = 1'b0; v = (xlen == 64) ? 64'(ins[15:10]) : 64'(ins[14:10]); end
      I12: begin v = 64'(ins[21:10]); w = 12; s = !u; end
      I14: begin v = 64'({ins[23:10], 2'b00}); w = 16; end
      I16: begin v = 64'({ins[25:10], 2'b00}); w = 18; end
      I20: begin v = 64'({ins[24:5], 12'h000}); w = 32; end
      I21: begin v = 64'({ins[4:0], ins[25:10]}); w = 21; end
      I26: begin v = 64'({ins[9:0], ins[25:10], 2'b00}); w = 28; end
      default: s = 1'b0;
    endcase
    if (s && v[w-1]) v = v - (64'd1 << w);
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  function automatic logic [63:0] ref_tgt(input logic [63:0] pcv, input logic [63:0] immv,
                                          input logic p, input bit bad,
                                          input int unsigned xlen, input bit en);
    logic [63:0] s;
    if (!en || !p || bad) return 64'd0;
    s = pcv + immv;
    if (xlen == 32) s = s & 64'h0000_0000_FFFF_FFFF;
    return s;
  endfunction

  task automatic check_all();
    req_t r;
    logic [63:0] e32, e64;
    bit bad;
    check_eq("in_ready32", 64'(b32.in_ready), 64'(q.size() < 2));
    check_eq("in_ready64", 64'(b64.in_ready), 64'(q.size() < 2));
    check_eq("in_readynp", 64'(bnp.in_ready), 64'(q.size() < 2));
    check_eq("out_valid32", 64'(b32.out_valid), 64'(q.size() > 0));
    check_eq("out_valid64", 64'(b64.out_valid), 64'(q.size() > 0));
    check_eq("out_validnp", 64'(bnp.out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      r   = q[0];
      bad = ref_bad(r.t);
      e32 = ref_imm(r.instr, r.t, r.u, 32);
      e64 = ref_imm(r.instr, r.t, r.u, 64);
      check_eq("imm32", 64'(b32.imm), e32);
      check_eq("imm64", b64.imm, e64);
      check_eq("immnp", 64'(bnp.imm), e32);
      check_eq("target32", 64'(b32.target), ref_tgt(r.pc, e32, r.p, bad, 32, 1'b1));
      check_eq("target64", b64.target, ref_tgt(r.pc, e64, r.p, bad, 64, 1'b1));
      check_eq("targetnp", 64'(bnp.target), ref_tgt(r.pc, e32, r.p, bad, 32, 1'b0));
      check_eq("bad32", 64'(b32.bad_fmt), 64'(bad));
      check_eq("bad64", 64'(b64.bad_fmt), 64'(bad));
      check_eq("badnp", 64'(bnp.bad_fmt), 64'(bad));
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [3:0] t,
                       input logic u, input logic p, input logic [63:0] pcv,
                       input logic ordy, input logic fl);
    in_valid = v; instr = ins; itype_raw = t; unsign = u; pcrel = p; pc = pcv;
    out_ready = ordy; flush = fl;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 64'h0, ordy, 1'b0);
  endtask

  // Called just after a falling edge with inputs applied; returns at the next
  // falling edge with the model advanced across the rising edge.
  task automatic tick();
    req_t r;
    bit accept, pop;
    check_all();
    accept = in_valid && (q.size() < 2);
    pop    = (q.size() > 0) && out_ready;
    r.instr = instr; r.t = itype_raw; r.u = unsign; r.p = pcrel; r.pc = pc;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (accept) q.push_back(r);
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    idle(1'b0);
    @(negedge clk);
    check_eq("rst_out_valid", 64'(b32.out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(b64.in_ready), 64'd1);
    check_eq("rst_imm", b64.imm, 64'd0);
    check_eq("rst_target", 64'(b32.target), 64'd0);
    check_eq("rst_bad", 64'(bnp.bad_fmt), 64'd0);
    rst_n = 1'b1;

    // I12 sign / zero extension
    drive(1'b1, 32'hFFF << 10, 4'(I12), 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    tick();
    check_eq("i12_signed", 64'(b32.imm), 64'hFFFF_FFFF);
    drive(1'b1, 32'hFFF << 10, 4'(I12), 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
    tick();
    check_eq("i12_unsigned", 64'(b32.imm), 64'h0000_0FFF);

    // 64-bit I16 and I26
    drive(1'b1, 32'h8000 << 10, 4'(I16), 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    tick();
    check_eq("i16_64", b64.imm, 64'hFFFF_FFFF_FFFE_0000);
    drive(1'b1, 32'h03FF_FFFF, 4'(I26), 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    tick();
    check_eq("i26_64", b64.imm, 64'hFFFF_FFFF_FFFF_FFFC);

    // I20 pc-relative
    drive(1'b1, 32'h12345 << 5, 4'(I20), 1'b0, 1'b1, 64'h1C00_0000, 1'b1, 1'b0);
    tick();
    check_eq("i20_imm", 64'(b32.imm), 64'h1234_5000);
    check_eq("i20_target", 64'(b32.target), 64'h2E34_5000);
    check_eq("i20_target_nopcrel", 64'(bnp.target), 64'h0);
    idle(1'b1);
    tick();

    // A, B, C under a 3-cycle output stall
    drive(1'b1, 32'h0000_1400, 4'(I12), 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h0000_2800, 4'(I12), 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    tick();
    check_eq("stall_in_ready", 64'(b32.in_ready), 64'd0);
    drive(1'b1, 32'h0000_3C00, 4'(I12), 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    tick();
    out_ready = 1'b1;
    tick();
    tick();
    idle(1'b1);
    for (int unsigned i = 0; i < 4; i++) tick();

    // Flush with skid full and a request presented
    drive(1'b1, 32'h0100_0000, 4'(I14), 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b1, 32'h00FF_0000, 4'(I21), 1'b0, 1'b1, 64'h40, 1'b0, 1'b1);
    tick();
    check_eq("flush_out_valid", 64'(b32.out_valid), 64'd0);
    check_eq("flush_in_ready", 64'(b32.in_ready), 64'd1);
    idle(1'b1);
    for (int unsigned i = 0; i < 3; i++) tick();

    // Asynchronous reset during a stall
    drive(1'b1, 32'h0000_5400, 4'(I8), 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    tick();
    tick();
    #1 rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", 64'(b64.out_valid), 64'd0);
    check_eq("arst_in_ready", 64'(b64.in_ready), 64'd1);
    check_eq("arst_imm", b64.imm, 64'd0);
    q.delete();
    idle(1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1, 64'h1234, 1'b1, 1'b0);
    tick();
    check_eq("undef_bad", 64'(b32.bad_fmt), 64'd1);
    check_eq("undef_imm", 64'(b32.imm), 64'd0);
    idle(1'b1);
    tick();

    // Randomized traffic
    for (int unsigned i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 9) < 7),
            $urandom,
            ($urandom_range(0, 9) < 8) ? 4'($urandom_range(1, 7)) : 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            {$urandom, $urandom},
            1'($urandom_range(0, 9) < 6),
            1'($urandom_range(0, 19) == 0));
      tick();
    end
    idle(1'b1);
    for (int unsigned i = 0; i < 3; i++) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width of immediate, pc and target; legal values 32 and 64.
REQ-002 Parameter PC_REL_EN, default 1; when 1 the pc-relative adder exists, when 0 target is driven to 0.
REQ-003 Port clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port flush  input  1  synchronous pipeline flush.
REQ-006 Port in_valid  input  1  upstream request valid.
REQ-007 Port in_ready  output  1  block can accept a request this cycle.
REQ-008 Port instr  input  Instr (32)  raw instruction word.
REQ-009 Port itype  input  Itype  immediate format selector: I8, I12, I14, I16, I20, I21, I26, or other.
REQ-010 Port unsign  input  1  zero-extend I12 when high.
REQ-011 Port pcrel  input  1  request target = pc + imm.
REQ-012 Port pc  input  XLEN  address of instr.
REQ-013 Port out_valid  output  1  result valid.
REQ-014 Port out_ready  input  1  downstream accepts result.
REQ-015 Port imm  output  XLEN  extended immediate.
REQ-016 Port target  output  XLEN  pc + imm when pcrel, else 0.
REQ-017 Port bad_fmt  output  1  itype was not a defined format.

Function
REQ-018 Extension to XLEN: I8 zero-extends instr[14:10] (XLEN=64: instr[15:10]); I12 sign-/zero-extends instr[21:10] per unsign; I14 sign-extends {instr[23:10],2'b0}; I16 sign-extends {instr[25:10],2'b0}; I20 sign-extends {instr[24:5],12'b0}; I21 sign-extends {instr[4:0],instr[25:10]}; I26 sign-extends {instr[9:0],instr[25:10],2'b0}.
REQ-019 Undefined itype: imm=0, target=0, bad_fmt=1; otherwise bad_fmt=0.
REQ-020 target = (pc + imm) mod 2^XLEN when pcrel=1 and PC_REL_EN=1; carry-out discarded.
REQ-021 Transfer in on in_valid && in_ready; transfer out on out_valid && out_ready.
REQ-022 Latency exactly 1 cycle: request accepted at edge N is presented at out_valid after edge N with no stall.
REQ-023 Output stage plus one skid entry (2 entries total); in_ready = skid entry empty, registered (no combinational path from out_ready).
REQ-024 Output stall with valid result and new transfer in: new result goes to skid; in_ready drops next cycle.
REQ-025 Output transfer with skid full: skid moves to output stage, in_ready rises next cycle; order strictly FIFO.
REQ-026 Simultaneous in- and out-transfer with skid empty: output stage reloads with the new result, no bubble.
REQ-027 Output stable (imm, target, bad_fmt unchanged) while out_valid && !out_ready.
REQ-028 flush has priority over all transfers: next cycle out_valid=0, skid empty, in_ready=1; a request presented during flush is dropped.
REQ-029 Arithmetic computed before the register; outputs come straight from flops.

Reset
REQ-030 rst_n low asynchronously forces out_valid=0, skid empty, in_ready=1, imm=0, target=0, bad_fmt=0.
REQ-031 Reset asserted mid-stream discards all held results; first accept after deassert is the first cycle in_valid=1.

Structure
REQ-032 Instr, Itype (extended with I8..I26 encodings) and XLEN-independent format constants live in the shared cpuDefine package; an XLEN-parametrised data type is declared there.
REQ-033 One sub-module imm_ext: combinational format decode/extension (REQ-018, REQ-019), instantiated once; handshake and skid logic in imm_gen_pipe.

Verification
REQ-034 XLEN=32, I12, instr[21:10]=0xFFF, unsign=0 -> imm=0xFFFFFFFF; unsign=1 -> imm=0x00000FFF, 1 cycle later.
REQ-035 XLEN=64, I16, instr[25:10]=0x8000 -> imm=0xFFFFFFFFFFFE0000; I26 all ones -> imm=0xFFFFFFFFFFFFFFFC.
REQ-036 I20, instr[24:5]=0x12345, pcrel=1, pc=0x1C000000 -> imm=0x12345000, target=0x2E345000; PC_REL_EN=0 -> target=0.
REQ-037 Back-to-back requests A,B,C with out_ready=0 for 3 cycles -> in_ready low after B, outputs A,B,C in order once out_ready=1, no loss.
REQ-038 Skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed request never emitted.
REQ-039 rst_n low mid-stall -> out_valid=0 immediately without clock, in_ready=1; undefined itype afterwards -> bad_fmt=1, imm=0.
